cnt_delta_buffer: RTL and testbench

Downstream consumer of a free-running accumulator count (the 8-bit `cnt` produced by the counter/accumulator stage). Samples the count on enable, converts consecutive samples into per-sample increments (modulo 2^WIDTH) with a wrap flag, and buffers them in a small first-word-fall-through FIFO. A valid/ready handshake drains the FIFO to the next stage. A sticky flag reports dropped samples.

---
 rtl/cnt_delta_buffer.sv | 133 +++++++++++++
 tb/tb_cnt_delta_buffer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_delta_buffer.sv
// cnt_delta_buffer
//
// Samples a free-running accumulator count on enable, turns each pair of
// consecutive samples into an increment (modulo 2^WIDTH) plus a wrap flag,
// and queues the results in a small first-word-fall-through FIFO that is
// drained with a valid/ready handshake. A sticky flag records that at
// least one increment was lost because the FIFO was full.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_cnt     count value from the upstream accumulator (WIDTH bits)
//   in_en      sample in_cnt this cycle
//   out_valid  FIFO head holds an entry
//   out_ready  downstream accepts the head this cycle
//   out_delta  head increment, 0 when out_valid is low
//   out_wrap   head increment crossed the 2^WIDTH boundary, 0 when idle
//   level      current FIFO occupancy, 0..DEPTH
//   overflow   sticky: an increment was dropped since reset

module cnt_delta_buffer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int SKIP_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_cnt,
    input  logic                     in_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_delta,
    output logic                     out_wrap,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // PRIMED waits for the very first sample, which only seeds prev
    typedef enum logic {
        PRIMED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [WIDTH-1:0] delta;
    logic             wrap;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [WIDTH:0]   head;

    always_comb begin
        delta    = in_cnt - prev;
        wrap     = (in_cnt < prev);
        push_req = (state == RUN) && in_en &&
                   !((SKIP_ZERO != 0) && (delta == '0));
        out_valid = (level != '0);
        pop      = out_valid && out_ready;
        full     = (level == LW'(DEPTH));
        // a full FIFO still takes the new entry when the head leaves in the same cycle
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        head     = mem[rd_ptr];
        out_delta = out_valid ? head[WIDTH-1:0] : '0;
        out_wrap  = out_valid ? head[WIDTH] : 1'b0;
    end

    // prev tracks every accepted sample, even when its increment is dropped,
    // so the next increment is always relative to the latest sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIMED;
            prev  <= '0;
        end else begin
            case (state)
                PRIMED: begin
                    if (in_en) begin
                        prev  <= in_cnt;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (in_en) begin
                        prev <= in_cnt;
                    end
                end
                default: state <= PRIMED;
            endcase
        end
    end

    // storage needs no reset: level gates everything read out of it
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wrap, delta};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnt_delta_buffer.sv
// tb_cnt_delta_buffer
//
// Drives cnt_delta_buffer through a table of directed vectors, an
// asynchronous reset sequence, a SKIP_ZERO sequence on a second instance,
// and a long randomized run compared against a queue-based model.

module tb_cnt_delta_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_cnt;
    logic       in_en;
    logic       out_ready;

    logic       out_valid;
    logic [7:0] out_delta;
    logic       out_wrap;
    logic [2:0] level;
    logic       overflow;

    logic       sz_valid;
    logic [7:0] sz_delta;
    logic       sz_wrap;
    logic [2:0] sz_level;
    logic       sz_overflow;

    cnt_delta_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKIP_ZERO(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_cnt    (in_cnt),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .out_wrap  (out_wrap),
        .level     (level),
        .overflow  (overflow)
    );

    cnt_delta_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKIP_ZERO(1)) dut_skip (
        .clk       (clk),
        .rst       (rst),
        .in_cnt    (in_cnt),
        .in_en     (in_en),
        .out_valid (sz_valid),
        .out_ready (out_ready),
        .out_delta (sz_delta),
        .out_wrap  (sz_wrap),
        .level     (sz_level),
        .overflow  (sz_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] cnt;
        logic       ready;
        logic       valid;
        logic [7:0] delta;
        logic       wrap;
        logic [2:0] level;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] delta;
        logic       wrap;
    } entry_t;

    // reference model: a plain queue of pending increments
    entry_t     model_q[$];
    bit         model_primed;
    logic [7:0] model_prev;
    logic [7:0] model_first;
    bit         model_ovf;
    int         drop_sum;
    int         dut_pop_sum;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t vecs[22];

    function automatic vec_t mkVec(input int en, input int cnt, input int ready,
                                   input int valid, input int delta, input int wrap,
                                   input int lvl, input int ovf);
        vec_t v;
        v.en    = 1'(en);
        v.cnt   = 8'(cnt);
        v.ready = 1'(ready);
        v.valid = 1'(valid);
        v.delta = 8'(delta);
        v.wrap  = 1'(wrap);
        v.level = 3'(lvl);
        v.ovf   = 1'(ovf);
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_primed = 0;
        model_prev   = '0;
        model_first  = '0;
        model_ovf    = 0;
        drop_sum     = 0;
        dut_pop_sum  = 0;
    endtask

    task automatic modelStep(input logic en, input logic [7:0] cnt, input logic ready, input bit skip);
        entry_t     e;
        bit         have_push;
        logic [7:0] d;
        have_push = 0;
        if (ready && model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
        if (en) begin
            if (!model_primed) begin
                model_primed = 1;
                model_first  = cnt;
            end else begin
                d       = cnt - model_prev;
                e.delta = d;
                e.wrap  = (cnt < model_prev);
                if (!(skip && d == 0)) have_push = 1;
            end
            model_prev = cnt;
        end
        if (have_push) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(e);
            end else begin
                model_ovf = 1;
                drop_sum  += int'(e.delta);
            end
        end
    endtask

    task automatic checkAgainstModel(input string tag);
        int exp_valid;
        int exp_delta;
        int exp_wrap;
        exp_valid = (model_q.size() != 0) ? 1 : 0;
        exp_delta = exp_valid ? int'(model_q[0].delta) : 0;
        exp_wrap  = exp_valid ? int'(model_q[0].wrap) : 0;
        checkOutput({tag, " out_valid"}, int'(out_valid), exp_valid);
        checkOutput({tag, " out_delta"}, int'(out_delta), exp_delta);
        checkOutput({tag, " out_wrap"},  int'(out_wrap),  exp_wrap);
        checkOutput({tag, " level"},     int'(level),     model_q.size());
        checkOutput({tag, " overflow"},  int'(overflow),  int'(model_ovf));
    endtask

    // called at posedge+1; leaves the bench at the following posedge+1
    task automatic applyStimulus(input logic en, input logic [7:0] cnt, input logic ready);
        in_en     = en;
        in_cnt    = cnt;
        out_ready = ready;
        #4;
        if (out_valid && out_ready) dut_pop_sum += int'(out_delta);
        modelStep(en, cnt, ready, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in_en     = 1'b0;
        out_ready = 1'b0;
        in_cnt    = '0;
        rst       = 1'b1;
        modelReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // directed vectors: en cnt ready | valid delta wrap level ovf
        vecs[0]  = mkVec(1, 10,  1, 0, 0,   0, 0, 0);
        vecs[1]  = mkVec(1, 13,  1, 1, 3,   0, 1, 0);
        vecs[2]  = mkVec(1, 20,  1, 1, 7,   0, 1, 0);
        vecs[3]  = mkVec(0, 0,   1, 0, 0,   0, 0, 0);
        vecs[4]  = mkVec(1, 250, 0, 1, 230, 0, 1, 0);
        vecs[5]  = mkVec(1, 4,   1, 1, 10,  1, 1, 0);
        vecs[6]  = mkVec(1, 4,   1, 1, 0,   0, 1, 0);
        vecs[7]  = mkVec(0, 0,   1, 0, 0,   0, 0, 0);
        vecs[8]  = mkVec(1, 5,   0, 1, 1,   0, 1, 0);
        vecs[9]  = mkVec(1, 7,   0, 1, 1,   0, 2, 0);
        vecs[10] = mkVec(1, 10,  0, 1, 1,   0, 3, 0);
        vecs[11] = mkVec(1, 14,  0, 1, 1,   0, 4, 0);
        vecs[12] = mkVec(1, 19,  1, 1, 2,   0, 4, 0);
        vecs[13] = mkVec(1, 25,  0, 1, 2,   0, 4, 1);
        vecs[14] = mkVec(0, 0,   1, 1, 3,   0, 3, 1);
        vecs[15] = mkVec(0, 0,   1, 1, 4,   0, 2, 1);
        vecs[16] = mkVec(0, 0,   1, 1, 5,   0, 1, 1);
        vecs[17] = mkVec(0, 0,   1, 0, 0,   0, 0, 1);
        vecs[18] = mkVec(1, 26,  0, 1, 1,   0, 1, 1);
        vecs[19] = mkVec(0, 0,   0, 1, 1,   0, 1, 1);
        vecs[20] = mkVec(1, 28,  0, 1, 1,   0, 2, 1);
        vecs[21] = mkVec(1, 30,  0, 1, 1,   0, 3, 1);

        rst       = 1'b1;
        in_en     = 1'b0;
        in_cnt    = '0;
        out_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_delta", int'(out_delta), 0);
        checkOutput("reset out_wrap",  int'(out_wrap),  0);
        checkOutput("reset level",     int'(level),     0);
        checkOutput("reset overflow",  int'(overflow),  0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].en, vecs[i].cnt, vecs[i].ready);
            checkOutput($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].valid));
            checkOutput($sformatf("vec%0d out_delta", i), int'(out_delta), int'(vecs[i].delta));
            checkOutput($sformatf("vec%0d out_wrap", i),  int'(out_wrap),  int'(vecs[i].wrap));
            checkOutput($sformatf("vec%0d level", i),     int'(level),     int'(vecs[i].level));
            checkOutput($sformatf("vec%0d overflow", i),  int'(overflow),  int'(vecs[i].ovf));
        end

        // asynchronous reset in the middle of a cycle with level 3, overflow 1
        #2;
        in_en     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("async rst out_valid", int'(out_valid), 0);
        checkOutput("async rst out_delta", int'(out_delta), 0);
        checkOutput("async rst out_wrap",  int'(out_wrap),  0);
        checkOutput("async rst level",     int'(level),     0);
        checkOutput("async rst overflow",  int'(overflow),  0);
        modelReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 8'd77, 1'b1);
        checkOutput("reprime level",     int'(level),    0);
        checkOutput("reprime out_valid", int'(out_valid), 0);
        checkOutput("reprime skip level", int'(sz_level), 0);
        applyStimulus(1'b1, 8'd80, 1'b1);
        checkOutput("after prime delta",      int'(out_delta), 3);
        checkOutput("after prime level",      int'(level),     1);
        checkOutput("after prime skip delta", int'(sz_delta),  3);
        checkOutput("after prime skip level", int'(sz_level),  1);
        applyStimulus(1'b1, 8'd80, 1'b1);
        checkOutput("equal sample valid",  int'(out_valid), 1);
        checkOutput("equal sample delta",  int'(out_delta), 0);
        checkOutput("equal sample wrap",   int'(out_wrap),  0);
        checkOutput("equal sample level",  int'(level),     1);
        checkOutput("skip zero level",     int'(sz_level),  0);
        checkOutput("skip zero valid",     int'(sz_valid),  0);
        checkOutput("skip zero overflow",  int'(sz_overflow), 0);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("drain level", int'(level), 0);

        // long random run against the queue model
        doReset();
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(1'($urandom_range(0, 99) < 70), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 99) < 60));
            checkAgainstModel($sformatf("rand%0d", c));
        end
        for (int c = 0; c <= DEPTH; c++) begin
            applyStimulus(1'b0, 8'd0, 1'b1);
            checkAgainstModel($sformatf("drain%0d", c));
        end
        begin
            logic [7:0] span;
            span = model_prev - model_first;
            checkOutput("conservation", (dut_pop_sum + drop_sum) % 256, int'(span));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
